// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets several requesters share one ALU instance.
// Latches the winner's operands, sequences start/valid_out, and aborts hung ops with a watchdog.
module alu_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [32*NUM_REQ-1:0]   req_op_a,
   input  logic [32*NUM_REQ-1:0]   req_op_b,
   input  logic [3*NUM_REQ-1:0]    req_op_code,
   input  logic [NUM_REQ-1:0]      req_mode_fp,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic [31:0]             result,
   output logic [4:0]              flags,
   output logic                    timeout_err,
   output logic                    busy,
   output logic                    alu_rst,
   output logic                    alu_start,
   output logic [31:0]             alu_op_a,
   output logic [31:0]             alu_op_b,
   output logic [2:0]              alu_op_code,
   output logic                    alu_mode_fp,
   input  logic [31:0]             alu_result,
   input  logic                    alu_valid_out,
   input  logic [4:0]              alu_flags
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

   logic [1:0]    state;
   logic [IW-1:0] owner;
   logic [IW-1:0] last;
   logic [WW-1:0] wdog;
   logic          abort;

   logic          found;
   logic [IW-1:0] pick;
   logic [31:0]   pick_a;
   logic [31:0]   pick_b;
   logic [2:0]    pick_code;
   logic          pick_fp;

   // Scan starting just after the last served requester so every requester gets a turn.
   always_comb begin
      int idx;
      idx       = 0;
      found     = 1'b0;
      pick      = '0;
      pick_a    = '0;
      pick_b    = '0;
      pick_code = '0;
      pick_fp   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found     = 1'b1;
            pick      = IW'(idx);
            pick_a    = req_op_a[32*idx +: 32];
            pick_b    = req_op_b[32*idx +: 32];
            pick_code = req_op_code[3*idx +: 3];
            pick_fp   = req_mode_fp[idx];
         end
      end
   end

   assign alu_rst = rst | abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         owner       <= '0;
         last        <= LAST_INIT;
         wdog        <= '0;
         abort       <= 1'b0;
         gnt         <= '0;
         done        <= '0;
         result      <= '0;
         flags       <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         alu_start   <= 1'b0;
         alu_op_a    <= '0;
         alu_op_b    <= '0;
         alu_op_code <= '0;
         alu_mode_fp <= 1'b0;
      end else begin
         gnt         <= '0;
         done        <= '0;
         alu_start   <= 1'b0;
         timeout_err <= 1'b0;
         abort       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  alu_op_a    <= pick_a;
                  alu_op_b    <= pick_b;
                  alu_op_code <= pick_code;
                  alu_mode_fp <= pick_fp;
                  owner       <= pick;
                  gnt         <= NUM_REQ'(1) << pick;
                  alu_start   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_START;
               end
            end
            S_START: begin
               wdog  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // A valid on the final watchdog cycle still counts as a normal completion.
               if (alu_valid_out) begin
                  result <= alu_result;
                  flags  <= alu_flags;
                  done   <= NUM_REQ'(1) << owner;
                  state  <= S_DONE;
               end else if (wdog == WDOG_LAST) begin
                  result      <= '0;
                  flags       <= '0;
                  done        <= NUM_REQ'(1) << owner;
                  timeout_err <= 1'b1;
                  abort       <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            S_DONE: begin
               last  <= owner;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
